episode_scheduler: RTL
======================

EPISODE_SCHEDULER -- requirements
Module: episode_scheduler

Interface
REQ-001 Parameters SHALL be, one per line as name, default, meaning:
- STATES_WIDTH, 4, state index width.
- COUNTER_WIDTH, 8, step/episode counter width.
- MAX_STEPS, 16, step limit per episode (>=1).
- MAX_EPISODES, 8, episodes per run (>=1).
- GOAL_STATE, 15, terminal state index.
- TIMEOUT, 64, max cycles waiting for datapath.
REQ-002 The block has one clock; reset is asynchronous and active-low. Ports SHALL be, one per line as name, direction, width, meaning:
- clk  in  1  clock, rising edge.
- rst_n  in  1  asynchronous active-low reset.
- i_start  in  1  run request, level-sampled in IDLE.
- i_first_st  in  STATES_WIDTH  initial state of every episode.
- i_dtp_valid  in  1  datapath step-complete pulse.
- i_next_st  in  STATES_WIDTH  datapath next state, qualified by i_dtp_valid.
- o_dtp_valid  out  1  one-cycle step launch to datapath.
- o_cur_st  out  STATES_WIDTH  state for the launched step.
- o_step  out  COUNTER_WIDTH  step index within episode.
- o_count  out  COUNTER_WIDTH  episode index.
- o_write_file_en  out  1  one-cycle Q-table dump strobe.
- o_busy  out  1  run in progress.
- o_done  out  1  one-cycle run-complete pulse.
- o_err  out  1  sticky protocol/timeout error.

Function
REQ-003 FSM states SHALL be IDLE, ISSUE, WAIT, UPDATE, DUMP, DONE; encoding is free.
REQ-004 IDLE SHALL move to ISSUE when i_start=1 is sampled, and on that edge SHALL:
- latch i_first_st into both the first-state register and o_cur_st;
- clear o_step, o_count, o_err and the timeout counter.
REQ-005 ISSUE SHALL assert o_dtp_valid for exactly one cycle, then move to WAIT; the start-to-launch latency is 1 cycle.
REQ-006 WAIT SHALL hold until i_dtp_valid=1, latch i_next_st, then move to UPDATE.
REQ-007 The WAIT timeout counter SHALL clear on entering WAIT and increment each WAIT cycle. When it reaches TIMEOUT-1 with no i_dtp_valid, the block SHALL set o_err and go to IDLE without asserting o_write_file_en or o_done.
REQ-008 UPDATE SHALL detect end of episode when the latched next state equals GOAL_STATE or o_step equals MAX_STEPS-1.
REQ-009 UPDATE with no end of episode SHALL increment o_step, load the latched next state into o_cur_st, and go to ISSUE.
REQ-010 UPDATE at end of episode with o_count below MAX_EPISODES-1 SHALL increment o_count, clear o_step, reload o_cur_st from the first-state register, and go to ISSUE.
REQ-011 UPDATE at end of episode with o_count equal to MAX_EPISODES-1 SHALL go to DUMP; counters hold their values.
REQ-012 DUMP SHALL assert o_write_file_en for one cycle and go to DONE. DONE SHALL assert o_done for one cycle and go to IDLE.
REQ-013 The step-complete-to-next-launch latency SHALL be 2 cycles (UPDATE, then ISSUE).
REQ-014 o_busy SHALL be 1 in every state except IDLE.
REQ-015 i_start SHALL be ignored outside IDLE. If i_start is still high when the FSM returns to IDLE, a new run SHALL begin on the next edge.
REQ-016 i_dtp_valid sampled outside WAIT SHALL set o_err and be otherwise ignored; the FSM does not change state because of it.
REQ-017 o_err SHALL stay set until reset or the next run start.
REQ-018 A goal reached on the final allowed step SHALL be treated as a single end of episode, not counted twice.
REQ-019 Counters SHALL never wrap. Configurations with MAX_STEPS or MAX_EPISODES above 2^COUNTER_WIDTH are illegal.
REQ-020 i_first_st changes during a run SHALL have no effect until the next run start.

Reset
REQ-021 rst_n=0 SHALL force IDLE asynchronously and clear every output, the internal registers and the timeout counter.
REQ-022 Reset asserted mid-run SHALL abort the run with no o_write_file_en or o_done pulse. After rst_n rises, the block SHALL wait for a fresh i_start.

Verification (MAX_STEPS=4, MAX_EPISODES=2, GOAL_STATE=5, TIMEOUT=8)
REQ-023 Datapath never returns 5 -> each episode makes 4 launches with o_step 0..3. o_count goes 0 then 1. 8 launches total, then one o_write_file_en cycle, then o_done on the following cycle.
REQ-024 i_first_st=2, datapath returns 5 on the first step of each episode -> 2 launches total, both with o_cur_st=2. o_count 0 then 1. Dump then done.
REQ-025 Datapath returns 3 then 7 -> the launches carry o_cur_st 2, 3, 7, and o_step 0, 1, 2.
REQ-026 No i_dtp_valid for 8 WAIT cycles -> o_err=1, FSM returns to IDLE, o_busy=0, no dump strobe.
REQ-027 A spurious i_dtp_valid during ISSUE -> o_err=1 and launch sequencing is unchanged.
REQ-028 Reset pulsed during the second episode -> all outputs 0 immediately. Reasserting i_start restarts with o_count=0 and o_step=0.

Source files
------------

// File: rtl/episode_scheduler.sv
// episode_scheduler: sequences datapath steps over episodes, then dumps the Q-table
module episode_scheduler #(
  parameter int STATES_WIDTH  = 4,
  parameter int COUNTER_WIDTH = 8,
  parameter int MAX_STEPS     = 16,
  parameter int MAX_EPISODES  = 8,
  parameter int GOAL_STATE    = 15,
  parameter int TIMEOUT       = 64
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     i_start,
  input  logic [STATES_WIDTH-1:0]  i_first_st,
  input  logic                     i_dtp_valid,
  input  logic [STATES_WIDTH-1:0]  i_next_st,
  output logic                     o_dtp_valid,
  output logic [STATES_WIDTH-1:0]  o_cur_st,
  output logic [COUNTER_WIDTH-1:0] o_step,
  output logic [COUNTER_WIDTH-1:0] o_count,
  output logic                     o_write_file_en,
  output logic                     o_busy,
  output logic                     o_done,
  output logic                     o_err
);
  localparam int TW = $clog2(TIMEOUT + 1);
  typedef enum logic [2:0] {IDLE, ISSUE, WAIT, UPDATE, DUMP, DONE} state_t;
  state_t                  state;
  logic [STATES_WIDTH-1:0] first_st;
  logic [STATES_WIDTH-1:0] nxt_st;
  logic [TW-1:0]           tcnt;
  logic                    eoe;
  // episode ends on reaching the goal or on the last allowed step (a single event either way)
  always_comb eoe = (nxt_st == STATES_WIDTH'(GOAL_STATE)) || (o_step == COUNTER_WIDTH'(MAX_STEPS - 1));
  // run sequencer with registered strobes; stray datapath pulses only raise the error flag
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state           <= IDLE;
      first_st        <= '0;
      nxt_st          <= '0;
      tcnt            <= '0;
      o_dtp_valid     <= 1'b0;
      o_cur_st        <= '0;
      o_step          <= '0;
      o_count         <= '0;
      o_write_file_en <= 1'b0;
      o_busy          <= 1'b0;
      o_done          <= 1'b0;
      o_err           <= 1'b0;
    end else begin
      o_dtp_valid     <= 1'b0;
      o_write_file_en <= 1'b0;
      o_done          <= 1'b0;
      case (state)
        IDLE: if (i_start) begin
          first_st    <= i_first_st;
          o_cur_st    <= i_first_st;
          o_step      <= '0;
          o_count     <= '0;
          o_err       <= 1'b0;
          tcnt        <= '0;
          o_dtp_valid <= 1'b1;
          o_busy      <= 1'b1;
          state       <= ISSUE;
        end
        ISSUE: begin
          tcnt  <= '0;
          state <= WAIT;
        end
        WAIT: if (i_dtp_valid) begin
          nxt_st <= i_next_st;
          state  <= UPDATE;
        end else if (tcnt == TW'(TIMEOUT - 1)) begin
          o_err  <= 1'b1;
          o_busy <= 1'b0;
          state  <= IDLE;
        end else begin
          tcnt <= tcnt + 1'b1;
        end
        UPDATE: if (!eoe) begin
          o_step      <= o_step + 1'b1;
          o_cur_st    <= nxt_st;
          o_dtp_valid <= 1'b1;
          state       <= ISSUE;
        end else if (o_count < COUNTER_WIDTH'(MAX_EPISODES - 1)) begin
          o_count     <= o_count + 1'b1;
          o_step      <= '0;
          o_cur_st    <= first_st;
          o_dtp_valid <= 1'b1;
          state       <= ISSUE;
        end else begin
          o_write_file_en <= 1'b1;
          state           <= DUMP;
        end
        DUMP: begin
          o_done <= 1'b1;
          state  <= DONE;
        end
        DONE: begin
          o_busy <= 1'b0;
          state  <= IDLE;
        end
        default: state <= IDLE;
      endcase
      if (i_dtp_valid && state != WAIT) o_err <= 1'b1;
    end
  end
endmodule
